// File: rtl/dest_ip_pkg.sv
// Shared definitions for the destination-IP table controller: FSM encoding,
// table depth, requester IDs and default abort timeout.
package dest_ip_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    CLR_ISSUE = 3'd3,
    CLR_WAIT  = 3'd4
  } state_t;

  localparam int   TBL_DEPTH   = 32;
  localparam int   DEF_TIMEOUT = 16;
  localparam logic REQ_HOST    = 1'b0;
  localparam logic REQ_LRN     = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer and one-hot
// grant. Pointer 0 favours HOST; it flips away from whoever was granted.
module rr_arb2
  import dest_ip_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
    if (upd && (|gnt)) ptr_d = gnt[REQ_HOST];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dest_ip_tbl_ctrl.sv
// Arbitrates HOST/learn table accesses and a clear-all sweep onto one table port.
// Optional access abort on a missing table ack: define DEST_IP_TBL_CTRL_TIMEOUT_EN.
module dest_ip_tbl_ctrl
  import dest_ip_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic                          HOST_REQ,
  input  logic                          HOST_WR,
  input  logic [TBL_ADDR_WIDTH-1:0]     HOST_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] HOST_WDATA,
  output logic                          HOST_ACK,
  output logic [C_S_AXI_DATA_WIDTH-1:0] HOST_RDATA,
  output logic                          HOST_ERR,
  input  logic                          LRN_REQ,
  input  logic                          LRN_WR,
  input  logic [TBL_ADDR_WIDTH-1:0]     LRN_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] LRN_WDATA,
  output logic                          LRN_ACK,
  output logic [C_S_AXI_DATA_WIDTH-1:0] LRN_RDATA,
  output logic                          LRN_ERR,
  input  logic                          CLEAR_START,
  output logic                          CLEAR_BUSY,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack,
  output logic [31:0]                   TIMEOUT_COUNT
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = TBL_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(TBL_DEPTH - 1);
  localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
`ifdef DEST_IP_TBL_CTRL_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic          gid_q, gid_d, wr_q, wr_d, pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d, idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d, hrd_q, hrd_d, lrd_q, lrd_d;
  logic [31:0]   cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic          hack_q, hack_d, lack_q, lack_d, herr_q, herr_d, lerr_q, lerr_d;
  logic [1:0]    req_v, gnt;
  logic          clr_go, ack_ok, tmo_hit, clr_st;

  // A requester still sees its own ACK/ERR pulse with REQ high; mask it so
  // the same transaction is not granted twice.
  assign req_v[REQ_HOST] = HOST_REQ & ~hack_q & ~herr_q;
  assign req_v[REQ_LRN]  = LRN_REQ  & ~lack_q & ~lerr_q;
  assign clr_go  = pend_q | CLEAR_START;
  assign ack_ok  = wr_q ? tbl_wr_ack : tbl_rd_ack;
  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);
  assign clr_st  = (state_q == CLR_ISSUE) || (state_q == CLR_WAIT);

  rr_arb2 u_arb (
    .clk  (AXI_ACLK),
    .rst_n(AXI_RESETN),
    .req  (req_v),
    .upd  ((state_q == IDLE) && !clr_go),
    .gnt  (gnt)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    hrd_d   = hrd_q;
    lrd_d   = lrd_q;
    tcnt_d  = tcnt_q;
    cnt_d   = '0;
    hack_d  = 1'b0;
    lack_d  = 1'b0;
    herr_d  = 1'b0;
    lerr_d  = 1'b0;
    if (CLEAR_START && ((state_q == ISSUE) || (state_q == WAIT_ACK))) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (clr_go) begin
          state_d = CLR_ISSUE;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (|gnt) begin
          state_d = ISSUE;
          gid_d   = gnt[REQ_LRN];
          wr_d    = gnt[REQ_LRN] ? LRN_WR    : HOST_WR;
          addr_d  = gnt[REQ_LRN] ? LRN_ADDR  : HOST_ADDR;
          wdata_d = gnt[REQ_LRN] ? LRN_WDATA : HOST_WDATA;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        cnt_d = cnt_q + 32'd1;
        if (ack_ok) begin
          state_d = IDLE;
          if (gid_q == REQ_LRN) begin
            lack_d = 1'b1;
            if (!wr_q) lrd_d = tbl_rd_data;
          end else begin
            hack_d = 1'b1;
            if (!wr_q) hrd_d = tbl_rd_data;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          lerr_d  = (gid_q == REQ_LRN);
          herr_d  = (gid_q == REQ_HOST);
          if (tcnt_q != '1) tcnt_d = tcnt_q + 32'd1;
        end
      end
      CLR_ISSUE: state_d = CLR_WAIT;
      CLR_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        // A timed-out clear write just skips that entry.
        if (tbl_wr_ack || tmo_hit) begin
          if (!tbl_wr_ack && (tcnt_q != '1)) tcnt_d = tcnt_q + 32'd1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = CLR_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q <= IDLE;
      gid_q   <= REQ_HOST;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      hrd_q   <= '0;
      lrd_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      hack_q  <= 1'b0;
      lack_q  <= 1'b0;
      herr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      hrd_q   <= hrd_d;
      lrd_q   <= lrd_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      hack_q  <= hack_d;
      lack_q  <= lack_d;
      herr_q  <= herr_d;
      lerr_q  <= lerr_d;
    end
  end

  assign HOST_ACK      = hack_q;
  assign LRN_ACK       = lack_q;
  assign HOST_ERR      = herr_q;
  assign LRN_ERR       = lerr_q;
  assign HOST_RDATA    = hrd_q;
  assign LRN_RDATA     = lrd_q;
  assign TIMEOUT_COUNT = tcnt_q;
  assign CLEAR_BUSY    = pend_q | clr_st;
  assign tbl_rd_req    = (state_q == ISSUE) && !wr_q;
  assign tbl_wr_req    = ((state_q == ISSUE) && wr_q) || (state_q == CLR_ISSUE);
  assign tbl_rd_addr   = addr_q;
  assign tbl_wr_addr   = clr_st ? idx_q : addr_q;
  assign tbl_wr_data   = clr_st ? '0 : wdata_q;

endmodule
